// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RV32I widths, constants and the fetch FIFO entry type.
// Revision : 1.0
// ============================================================================
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Register-array FIFO with push/pop/flush and occupancy count.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: consumers only look at it while o_empty is low.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !w_do_pop && !i_flush));
endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit
// Purpose  : RV32I fetch front end: credit-limited sequential fetch, response
//            FIFO, redirect flush with stale-response discard.
//            Optional same-cycle response bypass: define FETCH_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module fetch_prefetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_W-1:0]     imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int OUT_W = $clog2(MAX_OUTST) + 1;

  logic              r_run;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [OUT_W-1:0]  r_outst;
  logic [OUT_W-1:0]  r_discard;

  logic              w_credit;
  logic              w_accept;
  logic              w_rsp_live;
  logic              w_bypass;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [XLEN-1:0]   w_sq_pc;
  logic              w_sq_empty;
  logic              w_sq_full;
  logic [$clog2(MAX_OUTST):0] w_sq_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic              w_unused_flags;

  // Occupancy plus in-flight words must fit, so a response can never find the FIFO full.
  assign w_credit = ((32'(fifo_count) + 32'(r_outst)) < 32'(DEPTH)) &&
                    (32'(r_outst) < 32'(MAX_OUTST));
  assign imem_req_valid = r_run && w_credit && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rsp_live     = imem_rsp_valid && (r_discard == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty && w_rsp_live;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_push  = w_rsp_live && !(w_bypass && out_ready);
  assign w_fifo_pop   = !w_fifo_empty && out_ready && !redirect_valid;
  assign w_push_entry = '{pc: w_sq_pc, instr: imem_rsp_data};

  assign out_valid = !w_fifo_empty || w_bypass;
  assign out_instr = w_bypass ? imem_rsp_data : (w_fifo_empty ? '0 : w_head.instr);
  assign out_pc    = w_bypass ? w_sq_pc       : (w_fifo_empty ? '0 : w_head.pc);

  assign w_unused_flags = &{1'b0, w_sq_empty, w_sq_full, w_sq_count, w_fifo_full};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        // A response landing this cycle is already dropped, so it is not owed to discard.
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_outst    <= r_outst - OUT_W'(imem_rsp_valid);
        r_discard  <= r_outst - OUT_W'(imem_rsp_valid);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
        r_outst <= r_outst + OUT_W'(w_accept) - OUT_W'(imem_rsp_valid);
        if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_accept),
    .i_pop   (w_rsp_live),
    .i_flush (redirect_valid),
    .i_wdata (r_fetch_pc),
    .o_rdata (w_sq_pc),
    .o_empty (w_sq_empty),
    .o_full  (w_sq_full),
    .o_count (w_sq_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (fifo_count)
  );
endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_unit
// Purpose  : Randomised scoreboard bench for fetch_prefetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_prefetch_unit;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT   = 1;
  localparam int EXP_MAXFC = 0;
`else
  localparam int EXP_LAT   = 2;
  localparam int EXP_MAXFC = 1;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fifo_count;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  mreq_t       memq[$];
  logic [63:0] expq[$];
  logic [31:0] sb_next;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, ordy_pct = 100;
  int          first_acc = -1, first_ov = -1, max_fc = 0, hs_cnt = 0;
  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed function of address; address 0 holds addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h0001_9E37);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference stream: after reset or redirect, fetch yields target, target+4, ...
  task automatic sb_restart(input logic [31:0] pc);
    expq.delete();
    sb_next = {pc[31:2], 2'b00};
  endtask

  // Monitor: checks outputs and invariants, and records accepted requests for the memory.
  always @(negedge clk) begin
    int          outst;
    int          d;
    logic [63:0] e;
    outst = memq.size() + int'(imem_rsp_valid);
    if (!reset) begin
      chk("rst_req_valid",  64'(imem_req_valid), 64'(0));
      chk("rst_out_valid",  64'(out_valid),      64'(0));
      chk("rst_out_instr",  64'(out_instr),      64'(0));
      chk("rst_out_pc",     64'(out_pc),         64'(0));
      chk("rst_fifo_count", 64'(fifo_count),     64'(0));
    end else begin
      chk("credit_sum", 64'(int'(fifo_count) + outst <= DEPTH), 64'(1));
      if (prev_redir) begin
        chk("post_redirect_count", 64'(fifo_count), 64'(0));
        chk("post_redirect_valid", 64'(out_valid),  64'(0));
      end
      if (prev_rv && !prev_rr && !redirect_valid) begin
        chk("req_valid_held", 64'(imem_req_valid), 64'(1));
        chk("req_addr_held",  64'(imem_req_addr),  64'(prev_addr));
      end
      if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready && !redirect_valid) begin
        while (expq.size() < 4) begin
          expq.push_back({sb_next, mem_word(sb_next)});
          sb_next = sb_next + 32'd4;
        end
        e = expq.pop_front();
        chk("out_pc",    64'(out_pc),    64'(e[63:32]));
        chk("out_instr", 64'(out_instr), 64'(e[31:0]));
        hs_cnt++;
      end
      if (imem_req_valid && imem_req_ready) begin
        if (first_acc < 0) first_acc = cyc;
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{imem_req_addr, d});
      end
    end
    prev_rv    = imem_req_valid && reset;
    prev_rr    = imem_req_ready;
    prev_addr  = imem_req_addr;
    prev_redir = redirect_valid && reset;
  end

  task automatic tick(input bit redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    out_ready      = redir ? 1'b0 : ($urandom_range(99, 0) < ordy_pct);
    redirect_valid = redir;
    redirect_pc    = redir ? rpc : $urandom;
    if (redir) sb_restart(rpc);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    memq.delete();
    last_due = 0;
    sb_restart(32'h0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    int  waited;
    reset = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    sb_restart(32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Streaming with an always-ready 1-cycle memory and an always-ready consumer.
    first_acc = -1; first_ov = -1; max_fc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) hs_cnt = 0;
      if (i == 30) chk("throughput", 64'(hs_cnt), 64'(20));
      tick(1'b0, 32'h0);
    end
    chk("first_out_latency", 64'(first_ov - first_acc), 64'(EXP_LAT));
    chk("max_fifo_count",    64'(max_fc),               64'(EXP_MAXFC));

    // Consumer stalled: credits must cap the FIFO at DEPTH and stop requests.
    ordy_pct = 0;
    repeat (20) tick(1'b0, 32'h0);
    @(negedge clk);
    chk("stall_fifo_count",  64'(fifo_count),     64'(DEPTH));
    chk("stall_req_valid",   64'(imem_req_valid), 64'(0));
    chk("stall_outstanding", 64'(memq.size() + int'(imem_rsp_valid)), 64'(0));
    ordy_pct = 100;

    // Redirect to 0x100 with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    waited = 0;
    while ((memq.size() + int'(imem_rsp_valid)) < 2 && waited < 40) begin
      tick(1'b0, 32'h0);
      waited++;
    end
    chk("wait_two_outstanding", 64'(waited < 40), 64'(1));
    tick(1'b1, 32'h0000_0100);
    hs_cnt = 0;
    repeat (25) tick(1'b0, 32'h0);
    chk("redirect_100_outputs", 64'(hs_cnt >= 2), 64'(1));

    // Misaligned redirect target.
    tick(1'b1, 32'h0000_0203);
    hs_cnt = 0;
    repeat (25) tick(1'b0, 32'h0);
    chk("redirect_203_outputs", 64'(hs_cnt >= 2), 64'(1));

    // Random back-pressure on both sides, random redirects, one mid-run reset.
    lat_min = 1; lat_max = 3; rdy_pct = 50; ordy_pct = 70;
    hs_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(2);
      else if ($urandom_range(99, 0) < 3)
        tick(1'b1, (i % 5 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0)) : $urandom);
      else
        tick(1'b0, 32'h0);
    end
    chk("random_outputs", 64'(hs_cnt > 300), 64'(1));

    summary();
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
